// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the MEM/WB slice: write-data source codes and the latched MEM/WB record.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    SEL_ALU = 3'd0,
    SEL_MEM = 3'd1,
    SEL_LUI = 3'd2,
    SEL_NPC = 3'd3
  } regsel_t;

  // reg_sel kept as raw bits so the illegal codes 4..7 survive the latch untouched.
  typedef struct packed {
    logic        valid;
    logic [31:0] npc;
    logic        reg_wr;
    logic [2:0]  reg_sel;
    logic [4:0]  reg_dst;
    logic [31:0] alu_out;
    logic [31:0] lui;
    logic        halt;
    logic [31:0] dmemload;
  } memwb_t;

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel < 3'd4;
  endfunction

endpackage

// File: rtl/writeback_if.sv
// Bundle carrying the latched MEM/WB record from the latch to the writeback logic.
interface writeback_if;
  import cpu_types_pkg::*;

  memwb_t latch;

  modport latch_mp (output latch);
  modport wb       (input  latch);
endinterface

// File: rtl/writeback_latch.sv
// MEM/WB pipeline register: flush loads a bubble, wben captures, freeze holds everything.
module writeback_latch
  import cpu_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              wben,
  input  memwb_t            din,
  writeback_if.latch_mp     bus
);

  memwb_t latch_q, latch_d;

  always_comb begin
    latch_d = latch_q;
    if (!freeze) begin
      if (flush)     latch_d = '0;
      else if (wben) latch_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) latch_q <= '0;
    else        latch_q <= latch_d;
  end

  assign bus.latch = latch_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB latch, RF write-data mux, forwarding outputs, sticky halt FSM
// and saturating retired-instruction counter.
module writeback_stage
  import cpu_types_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wben,
  input  logic             flush,
  input  logic [31:0]      nPC_next,
  input  logic             regWr_next,
  input  logic [2:0]       regSel_next,
  input  logic [4:0]       regDst_next,
  input  logic [31:0]      ALUOut_next,
  input  logic [31:0]      lui_next,
  input  logic             halt_next,
  input  logic [31:0]      dmemload,
  output logic             WEN,
  output logic [4:0]       wsel,
  output logic [31:0]      wdat,
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [31:0]      fwd_data,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {WB_RUN, WB_DRAIN, WB_HALTED} wb_state_t;

  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYC - 1);

  wb_state_t        state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halt_q, halt_d;
  logic             capture;
  memwb_t           din;
  memwb_t           lat;

  writeback_if wb_bus ();

  always_comb begin
    din          = '0;
    din.valid    = 1'b1;
    din.npc      = nPC_next;
    din.reg_wr   = regWr_next;
    din.reg_sel  = regSel_next;
    din.reg_dst  = regDst_next;
    din.alu_out  = ALUOut_next;
    din.lui      = lui_next;
    din.halt     = halt_next;
    din.dmemload = dmemload;
  end

  writeback_latch u_latch (
    .clk    (CLK),
    .rst_n  (nRST),
    .freeze (state_q == WB_HALTED),
    .flush  (flush),
    .wben   (wben),
    .din    (din),
    .bus    (wb_bus.latch_mp)
  );

  assign lat     = wb_bus.latch;
  assign capture = (state_q != WB_HALTED) && !flush && wben;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    case (state_q)
      WB_RUN: begin
        if (capture && halt_next) begin
          state_d = WB_DRAIN;
          cnt_d   = DRAIN_INIT;
        end else if (capture && (retired_q != '1)) begin
          retired_d = retired_q + 1'b1;
        end
      end
      WB_DRAIN: begin
        if (cnt_q == 2'd0) state_d = WB_HALTED;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = WB_HALTED;
    endcase
    halt_d = (state_d == WB_HALTED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= WB_RUN;
      cnt_q     <= 2'd0;
      retired_q <= '0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      halt_q    <= halt_d;
    end
  end

  // The HALT instruction and illegal select codes never reach the register file.
  always_comb begin
    WEN = lat.valid && lat.reg_wr && (lat.reg_dst != 5'd0) && !lat.halt &&
          sel_legal(lat.reg_sel) && (state_q != WB_HALTED);
    case (regsel_t'(lat.reg_sel))
      SEL_ALU: wdat = lat.alu_out;
      SEL_MEM: wdat = lat.dmemload;
      SEL_LUI: wdat = lat.lui;
      SEL_NPC: wdat = lat.npc;
      default: wdat = 32'd0;
    endcase
  end

  assign wsel      = lat.reg_dst;
  assign fwd_valid = WEN;
  assign fwd_reg   = wsel;
  assign fwd_data  = wdat;
  assign halt      = halt_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed + randomized bench for writeback_stage against a per-instruction reference model;
// runs a default instance and a CNT_W=4 / DRAIN_CYC=2 instance on shared stimulus.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        wben = 1'b0, flush = 1'b0, reg_wr = 1'b0, hnext = 1'b0;
  logic [31:0] npc = '0, alu = '0, lui = '0, dmem = '0;
  logic [2:0]  reg_sel = '0;
  logic [4:0]  reg_dst = '0;

  logic        wen0, fv0, halt0, wen1, fv1, halt1;
  logic [4:0]  wsel0, fr0, wsel1, fr1;
  logic [31:0] wdat0, fd0, wdat1, fd1, ret0;
  logic [3:0]  ret1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_stage #(.CNT_W(32), .DRAIN_CYC(1)) d0 (
    .CLK(clk), .nRST(nrst), .wben(wben), .flush(flush), .nPC_next(npc), .regWr_next(reg_wr),
    .regSel_next(reg_sel), .regDst_next(reg_dst), .ALUOut_next(alu), .lui_next(lui),
    .halt_next(hnext), .dmemload(dmem), .WEN(wen0), .wsel(wsel0), .wdat(wdat0),
    .fwd_valid(fv0), .fwd_reg(fr0), .fwd_data(fd0), .halt(halt0), .retired(ret0));

  writeback_stage #(.CNT_W(4), .DRAIN_CYC(2)) d1 (
    .CLK(clk), .nRST(nrst), .wben(wben), .flush(flush), .nPC_next(npc), .regWr_next(reg_wr),
    .regSel_next(reg_sel), .regDst_next(reg_dst), .ALUOut_next(alu), .lui_next(lui),
    .halt_next(hnext), .dmemload(dmem), .WEN(wen1), .wsel(wsel1), .wdat(wdat1),
    .fwd_valid(fv1), .fwd_reg(fr1), .fwd_data(fd1), .halt(halt1), .retired(ret1));

  // Reference model: the last instruction seen by WB plus a halt deadline in edge counts.
  typedef struct {
    bit          have;
    bit [31:0]   npc, alu, lui, mem;
    bit          wr, hlt;
    bit [2:0]    sel;
    bit [4:0]    dst;
    int          edges, hedge;
    bit          hseen, halted;
    longint      ret;
  } mdl_t;

  mdl_t   m [2];
  int     dcyc [2] = '{1, 2};
  longint rmax [2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) m[k] = '{default: 0};
  endtask

  task automatic model_edge(input int k);
    if (!m[k].halted && flush) begin
      m[k].have = 0; m[k].npc = 0; m[k].alu = 0; m[k].lui = 0; m[k].mem = 0;
      m[k].wr = 0; m[k].hlt = 0; m[k].sel = 0; m[k].dst = 0;
    end else if (!m[k].halted && wben) begin
      m[k].have = 1; m[k].npc = npc; m[k].alu = alu; m[k].lui = lui; m[k].mem = dmem;
      m[k].wr = reg_wr; m[k].hlt = hnext; m[k].sel = reg_sel; m[k].dst = reg_dst;
      if (!m[k].hseen) begin
        if (hnext) begin
          m[k].hseen = 1;
          m[k].hedge = m[k].edges + 1 + dcyc[k];
        end else if (m[k].ret < rmax[k]) m[k].ret++;
      end
    end
    m[k].edges++;
    if (m[k].hseen && m[k].edges >= m[k].hedge) m[k].halted = 1;
  endtask

  function automatic bit e_wen(input int k);
    return m[k].have && m[k].wr && m[k].dst != 0 && m[k].sel < 4 && !m[k].hlt && !m[k].halted;
  endfunction

  function automatic logic [31:0] e_wdat(input int k);
    case (m[k].sel)
      3'd0: return m[k].alu;
      3'd1: return m[k].mem;
      3'd2: return m[k].lui;
      3'd3: return m[k].npc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0_wen", 32'(wen0), 32'(e_wen(0)));
    chk("d0_wsel", 32'(wsel0), 32'(m[0].dst));
    chk("d0_wdat", wdat0, e_wdat(0));
    chk("d0_fwd", {fv0, 26'(fr0), 5'd0} ^ fd0, {e_wen(0), 26'(m[0].dst), 5'd0} ^ e_wdat(0));
    chk("d0_halt", 32'(halt0), 32'(m[0].halted));
    chk("d0_ret", ret0, 32'(m[0].ret));
    chk("d1_wen", 32'(wen1), 32'(e_wen(1)));
    chk("d1_wdat", wdat1, e_wdat(1));
    chk("d1_halt", 32'(halt1), 32'(m[1].halted));
    chk("d1_ret", 32'(ret1), 32'(m[1].ret));
  endtask

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_ins(input logic w, input logic [2:0] s, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] mm, input logic [31:0] pc);
    reg_wr = w; reg_sel = s; reg_dst = d; alu = a; dmem = mm; npc = pc;
    lui = $urandom; hnext = 1'b0;
  endtask

  task automatic rnd_ins();
    reg_wr  = $urandom_range(0, 3) != 0;
    reg_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    reg_dst = 5'($urandom);
    npc = $urandom; alu = $urandom; lui = $urandom; dmem = $urandom;
    hnext = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2;
    nrst = 1'b1;
  endtask

  initial begin
    logic [31:0] saved0;
    logic [3:0]  saved1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    do_reset();

    // ALU write
    wben = 1; set_ins(1, 3'd0, 5'd8, 32'h1234, 32'h0, 32'h4);
    tick();
    chk("alu_wen", 32'(wen0), 32'd1);
    chk("alu_wsel", 32'(wsel0), 32'd8);
    chk("alu_wdat", wdat0, 32'h1234);

    // Load, stall two cycles with changing inputs, then flush
    set_ins(1, 3'd1, 5'd9, 32'h55, 32'hDEADBEEF, 32'h8);
    tick();
    wben = 0;
    for (int i = 0; i < 2; i++) begin
      rnd_ins();
      tick();
      chk("stall_wdat", wdat0, 32'hDEADBEEF);
    end
    flush = 1;
    tick();
    flush = 0;
    chk("flush_wen", 32'(wen0), 32'd0);
    chk("flush_ret", ret0, 32'd2);

    // $zero destination, illegal select, JAL link value
    wben = 1;
    set_ins(1, 3'd0, 5'd0, 32'h77, 32'h0, 32'h0);
    tick();
    chk("zero_wen", 32'(wen0), 32'd0);
    set_ins(1, 3'd5, 5'd3, 32'h99, 32'h98, 32'h97);
    tick();
    chk("illsel_wen", 32'(wen0), 32'd0);
    chk("illsel_wdat", wdat0, 32'd0);
    set_ins(1, 3'd3, 5'd31, 32'h1, 32'h2, 32'h40);
    tick();
    chk("jal_wdat", wdat0, 32'h40);

    // Random traffic, no halts
    for (int i = 0; i < 200; i++) begin
      rnd_ins();
      wben  = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 7) == 0;
      tick();
    end
    flush = 0;

    // Flush squashes a simultaneous halt
    wben = 1; rnd_ins(); hnext = 1; flush = 1;
    tick();
    flush = 0; hnext = 0;
    for (int i = 0; i < 3; i++) begin
      rnd_ins();
      tick();
      chk("squash_halt", 32'(halt0), 32'd0);
    end

    // Halt: d0 drains 1 cycle, d1 drains 2
    rnd_ins(); hnext = 1;
    tick();
    hnext = 0;
    chk("drain_halt0", 32'(halt0), 32'd0);
    chk("halt_instr_wen", 32'(wen0), 32'd0);
    rnd_ins();
    tick();
    chk("halted0", 32'(halt0), 32'd1);
    chk("drain_halt1", 32'(halt1), 32'd0);
    rnd_ins();
    tick();
    chk("halted1", 32'(halt1), 32'd1);
    saved0 = ret0;
    saved1 = ret1;
    for (int i = 0; i < 10; i++) begin
      rnd_ins(); reg_wr = 1; wben = 1; flush = (i == 5);
      tick();
      chk("halted_wen", 32'(wen0), 32'd0);
      chk("frozen_ret0", ret0, saved0);
      chk("frozen_ret1", 32'(ret1), 32'(saved1));
      chk("sticky_halt", 32'(halt0), 32'd1);
    end
    flush = 0;

    // Reset pulse while draining
    do_reset();
    wben = 1; rnd_ins();
    tick();
    hnext = 1;
    tick();
    hnext = 0; wben = 0;
    nrst = 1'b0;
    #1;
    model_reset();
    chk("rst_drain_halt", 32'(halt0), 32'd0);
    chk("rst_drain_ret", ret0, 32'd0);
    check_all();
    @(posedge clk);
    #2;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_halt", 32'(halt0), 32'd0);
    end

    // Saturation of the narrow counter
    do_reset();
    wben = 1;
    for (int i = 0; i < 17; i++) begin
      rnd_ins();
      tick();
    end
    chk("sat_ret1", 32'(ret1), 32'd15);
    chk("nosat_ret0", ret0, 32'd17);
    wben = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
